// File: rtl/addr_sweeper_pkg.sv
// addr_sweeper_pkg: shared mode type and synchronizer depth for the address sweeper.
package addr_sweeper_pkg;
    typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} mode_t;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sync_rise.sv
// sync_rise: N-flop synchronizer followed by a rising-edge detect giving a one-cycle pulse.
module sync_rise #(
    parameter int N = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din_i,
    output logic rise_o
);
    logic [N-1:0] sync_q;
    logic         last_q;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], din_i};
            last_q <= sync_q[N-1];
        end
    end
    assign rise_o = sync_q[N-1] & ~last_q;
endmodule

// File: rtl/addr_sweeper.sv
// addr_sweeper: steps a RAM read address on rises of a divided-clock tap (RUN) or a manual step (PAUSE),
// emitting single-cycle tick/wrap strobes on the system clock.
module addr_sweeper
    import addr_sweeper_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       divided_clocks,
    input  logic [4:0]        sel,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              tick,
    output logic              wrap,
    output logic              mode
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    mode_t             mode_q;
    logic              tap_q;
    logic [4:0]        sel_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tick_q, tick_d, wrap_q, wrap_d;
    logic              tap, tap_rise, step_rise, adv, at_last;
    sync_rise #(.N(SYNC_STAGES)) u_step (
        .clock  (clock),
        .reset_n(reset_n),
        .din_i  (step),
        .rise_o (step_rise)
    );
    // a tap change masks the rise check so switching rates never fakes an edge
    assign tap      = divided_clocks[sel];
    assign tap_rise = tap & ~tap_q & (sel == sel_q);
    assign adv      = (mode_q == RUN) ? tap_rise : step_rise;
    assign at_last  = addr_q == LAST;
    always_comb begin
        addr_d = adv ? (at_last ? '0 : addr_q + 1'b1) : addr_q;
        tick_d = adv;
        wrap_d = adv & at_last;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mode_q <= PAUSE;
            tap_q  <= 1'b0;
            sel_q  <= '0;
            addr_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_t'(run);
            tap_q  <= tap;
            sel_q  <= sel;
            addr_q <= addr_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end
    assign addr = addr_q;
    assign tick = tick_q;
    assign wrap = wrap_q;
    assign mode = mode_q;
endmodule

// File: tb/tb_addr_sweeper.sv
// tb_addr_sweeper: scoreboard bench driving a 32-deep and a 10-deep sweeper from shared stimulus.
module tb_addr_sweeper;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0, run = 1'b0, step = 1'b0, div_en = 1'b1;
    logic [31:0] div = '0;
    logic [4:0]  sel = '0;
    logic [4:0]  addr32;
    logic [3:0]  addr10;
    logic        tick32, wrap32, mode32, tick10, wrap10, mode10;
    int          n_chk = 0, n_fail = 0;
    always #5 clock = ~clock;
    addr_sweeper #(.ADDR_W(5), .DEPTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .divided_clocks(div), .sel(sel), .run(run), .step(step),
        .addr(addr32), .tick(tick32), .wrap(wrap32), .mode(mode32)
    );
    addr_sweeper #(.ADDR_W(4), .DEPTH(10)) dut10 (
        .clock(clock), .reset_n(reset_n), .divided_clocks(div), .sel(sel), .run(run), .step(step),
        .addr(addr10), .tick(tick10), .wrap(wrap10), .mode(mode10)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    // reference model: pushes {wrap, addr} expectations when it predicts an advance
    logic       m_mode = 1'b0, m_tq = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0, m_sq = 1'b0;
    logic [4:0] m_selq = '0, m_a32 = '0;
    logic [3:0] m_a10 = '0;
    logic [5:0] q32[$];
    logic [4:0] q10[$];
    always @(posedge clock) begin : model
        logic tap, adv;
        if (!reset_n) begin
            {m_mode, m_tq, m_s1, m_s2, m_sq} = '0;
            m_selq = '0;
            m_a32  = '0;
            m_a10  = '0;
        end else begin
            tap = div[sel];
            adv = m_mode ? (tap && !m_tq && sel == m_selq) : (m_s2 && !m_sq);
            if (adv) begin
                m_a32 = (m_a32 == 5'd31) ? 5'd0 : m_a32 + 5'd1;
                m_a10 = (m_a10 == 4'd9) ? 4'd0 : m_a10 + 4'd1;
                q32.push_back({m_a32 == 5'd0, m_a32});
                q10.push_back({m_a10 == 4'd0, m_a10});
            end
            m_sq = m_s2; m_s2 = m_s1; m_s1 = step;
            m_tq = tap; m_selq = sel; m_mode = run;
        end
    end
    logic prev32 = 1'b0;
    always @(negedge clock) begin : scoreboard
        logic [5:0] e32;
        logic [4:0] e10;
        check("tick32", tick32, q32.size() != 0);
        check("tick10", tick10, q10.size() != 0);
        if (q32.size() != 0) begin
            e32 = q32.pop_front();
            check("addr32_tick", addr32, e32[4:0]);
            check("wrap32", wrap32, e32[5]);
        end else check("wrap32_idle", wrap32, 0);
        if (q10.size() != 0) begin
            e10 = q10.pop_front();
            check("addr10_tick", addr10, e10[3:0]);
            check("wrap10", wrap10, e10[4]);
        end else check("wrap10_idle", wrap10, 0);
        check("addr32", addr32, m_a32);
        check("addr10", addr10, m_a10);
        check("mode32", mode32, m_mode);
        check("mode10", mode10, m_mode);
        check("range10", addr10 < 4'd10, 1);
        check("tick_gap", tick32 & prev32, 0);
        prev32 = tick32;
    end
    task automatic cyc();
        @(posedge clock);
        #1;
        if (div_en) div = div + 1;
    endtask
    task automatic press();
        step = 1'b1;
        repeat (20) cyc();
        step = 1'b0;
        repeat (5) cyc();
    endtask
    initial begin
        int n;
        logic [4:0] a;
        run = 1'b1;
        repeat (3) cyc();
        check("rst_addr", addr32, 0);
        check("rst_mode", mode32, 0);
        check("rst_tick", tick32, 0);
        reset_n = 1'b1;
        repeat (110) cyc();
        // switch taps on a cycle where bit1 is high and the old tap flop is low
        sel = 5'd3;
        repeat (20) cyc();
        for (int i = 0; i < 40 && div[3:0] != 4'd2; i++) cyc();
        sel = 5'd1;
        n = 0;
        do begin cyc(); n++; end while (!tick32 && n < 20);
        check("tap_switch_lat", n, 5);
        sel = 5'd0;
        repeat (4) cyc();
        for (int i = 0; i < 4 && !div[0]; i++) cyc();
        a = addr32;
        run = 1'b0;
        cyc();
        check("old_mode_tick", tick32, 1);
        check("old_mode_addr", addr32, (a == 5'd31) ? 5'd0 : a + 5'd1);
        run = 1'b1;
        div_en = 1'b0;
        repeat (3) cyc();
        a = addr32;
        press();
        check("step_in_run", addr32, a);
        reset_n = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b1;
        run = 1'b0;
        div_en = 1'b1;
        for (int i = 0; i < 5; i++) press();
        check("pause_addr5", addr32, 5);
        step = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!tick32 && n < 30);
        check("step_lat", n, 3);
        repeat (20) cyc();
        step = 1'b0;
        repeat (5) cyc();
        check("pause_addr6", addr32, 6);
        press();
        check("pause_addr7", addr32, 7);
        repeat (3) cyc();
        check("sb_empty", q32.size() + q10.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
